// File: rtl/tsp_cmd_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tsp_cmd_sequencer
//  Purpose  : Owns the logic_ram register bus and expands one-shot job
//             requests (enable filter, load replacer packet, read captured
//             packet) into the exact INDEX/PID/CMD/STATUS/TS_DATA accesses.
//  Revision : 1.0 - initial release
// ============================================================================
module tsp_cmd_sequencer #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int OPT_MEM_ADDR_BITS  = 10,
  parameter int ALL_FILTERS_NUM    = 64,
  parameter int PACK_WORD_SIZE     = 47,
  parameter int POLL_TIMEOUT       = 1024
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [1:0]                      req_op,
  input  logic [31:0]                     req_index,
  input  logic [31:0]                     req_pid,
  input  logic                            wr_word_valid,
  output logic                            wr_word_ready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   wr_word,
  output logic                            rd_word_valid,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   rd_word,
  output logic                            rd_word_last,
  output logic                            done,
  output logic                            error,
  output logic                            mem_wren,
  output logic                            mem_rden,
  output logic [OPT_MEM_ADDR_BITS:0]      mem_address,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   mem_wdata,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   axi_rdata
);

  localparam int AW = OPT_MEM_ADDR_BITS + 1;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int KW = $clog2(PACK_WORD_SIZE);

  // Register map
  localparam logic [AW-1:0] A_INDEX  = AW'(0);
  localparam logic [AW-1:0] A_PID    = AW'(1);
  localparam logic [AW-1:0] A_RUN    = AW'(2);
  localparam logic [AW-1:0] A_CMD    = AW'(3);
  localparam logic [AW-1:0] A_STATUS = AW'(4);
  localparam logic [AW-1:0] A_TS     = AW'(128);

  localparam logic [DW-1:0] CMD_WRITE_REPLACE = DW'(1);
  localparam logic [DW-1:0] CMD_READ_REQUEST  = DW'(2);

  localparam logic [1:0] OP_ENABLE = 2'd0;
  localparam logic [1:0] OP_LOAD   = 2'd1;
  localparam logic [1:0] OP_READ   = 2'd2;
  localparam logic [1:0] OP_RSVD   = 2'd3;

  localparam logic [KW-1:0] K_LAST    = KW'(PACK_WORD_SIZE - 1);
  localparam logic [15:0]   POLL_LAST = 16'(POLL_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_W_INDEX = 4'd1,
    S_W_PID   = 4'd2,
    S_W_CMD   = 4'd3,
    S_W_DATA  = 4'd4,
    S_W_RUN   = 4'd5,
    S_POLL    = 4'd6,
    S_R_DATA  = 4'd7,
    S_R_WAIT  = 4'd8,
    S_DONE    = 4'd9
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [31:0]   index_q, index_d;
  logic [31:0]   pid_q, pid_d;
  logic [KW-1:0] k_q, k_d;
  logic [15:0]   poll_cnt_q, poll_cnt_d;
  logic          poll_first_q, poll_first_d;
  logic          err_q, err_d;
  logic          ready_q;
  logic          rdv_q;
  logic          rdl_q;

  logic          bad_req;
  logic          poll_sample;
  logic          status_ok;

  assign bad_req     = (req_index >= 32'(ALL_FILTERS_NUM)) || (req_op == OP_RSVD);
  // The first POLL cycle only issues the read; data is sampled from then on.
  assign poll_sample = !poll_first_q;
  assign status_ok   = (axi_rdata == DW'(1));

  // req_ready is registered so that it stays low while reset is asserted.
  assign req_ready     = ready_q;
  assign rd_word_valid = rdv_q;
  assign rd_word_last  = rdl_q;
  // Read data comes back one cycle after the address, so it is forwarded as-is.
  assign rd_word       = rdv_q ? axi_rdata : '0;

  // Next-state, job bookkeeping and bus outputs for the sequencer FSM.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    index_d       = index_q;
    pid_d         = pid_q;
    k_d           = k_q;
    poll_cnt_d    = poll_cnt_q;
    poll_first_d  = poll_first_q;
    err_d         = err_q;
    mem_wren      = 1'b0;
    mem_rden      = 1'b0;
    mem_address   = '0;
    mem_wdata     = '0;
    wr_word_ready = 1'b0;
    done          = 1'b0;
    error         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          op_d       = req_op;
          index_d    = req_index;
          pid_d      = req_pid;
          k_d        = '0;
          poll_cnt_d = '0;
          err_d      = bad_req;
          state_d    = bad_req ? S_DONE : S_W_INDEX;
        end
      end

      S_W_INDEX: begin
        mem_wren    = 1'b1;
        mem_address = A_INDEX;
        mem_wdata   = DW'(index_q);
        state_d     = (op_q == OP_READ) ? S_W_CMD : S_W_PID;
      end

      S_W_PID: begin
        mem_wren    = 1'b1;
        mem_address = A_PID;
        mem_wdata   = DW'(pid_q & 32'h0000_1FFF);
        state_d     = (op_q == OP_LOAD) ? S_W_CMD : S_W_RUN;
      end

      S_W_CMD: begin
        mem_wren    = 1'b1;
        mem_address = A_CMD;
        if (op_q == OP_LOAD) begin
          mem_wdata = CMD_WRITE_REPLACE;
          state_d   = S_W_DATA;
        end else begin
          mem_wdata    = CMD_READ_REQUEST;
          poll_first_d = 1'b1;
          poll_cnt_d   = '0;
          state_d      = S_POLL;
        end
      end

      S_W_DATA: begin
        wr_word_ready = 1'b1;
        mem_wren      = wr_word_valid;
        mem_address   = A_TS + AW'(k_q);
        mem_wdata     = wr_word;
        if (wr_word_valid) begin
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = S_W_RUN;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end

      S_W_RUN: begin
        mem_wren    = 1'b1;
        mem_address = A_RUN;
        mem_wdata   = DW'(1);
        state_d     = S_DONE;
      end

      S_POLL: begin
        // On the sample that would be the last allowed one, the read issued
        // now could never be looked at, so it is suppressed.
        mem_rden     = !(poll_sample && (poll_cnt_q == POLL_LAST));
        mem_address  = A_STATUS;
        poll_first_d = 1'b0;
        if (poll_sample) begin
          if (status_ok) begin
            k_d     = '0;
            state_d = S_R_DATA;
          end else if (poll_cnt_q == POLL_LAST) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            poll_cnt_d = poll_cnt_q + 16'd1;
          end
        end
      end

      S_R_DATA: begin
        mem_rden    = 1'b1;
        mem_address = A_TS + AW'(k_q);
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = S_R_WAIT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      // Lets the final readback word come out before done.
      S_R_WAIT: begin
        state_d = S_DONE;
      end

      S_DONE: begin
        done    = 1'b1;
        error   = err_q;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, latched job fields and registered handshake/readback strobes.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q      <= S_IDLE;
      op_q         <= 2'd0;
      index_q      <= '0;
      pid_q        <= '0;
      k_q          <= '0;
      poll_cnt_q   <= '0;
      poll_first_q <= 1'b0;
      err_q        <= 1'b0;
      ready_q      <= 1'b0;
      rdv_q        <= 1'b0;
      rdl_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      index_q      <= index_d;
      pid_q        <= pid_d;
      k_q          <= k_d;
      poll_cnt_q   <= poll_cnt_d;
      poll_first_q <= poll_first_d;
      err_q        <= err_d;
      ready_q      <= (state_d == S_IDLE);
      rdv_q        <= (state_q == S_R_DATA);
      rdl_q        <= (state_q == S_R_DATA) && (k_q == K_LAST);
    end
  end

endmodule
`default_nettype wire
